mmio_status_port: RTL and testbench

Memory-mapped responder on the CPU data-memory bus: decodes the processor's `memwrite`/`dataadr`/`writedata` transactions aimed at a small status window and answers reads from it. It turns the self-check convention of the MIPS test programs (store value 7 to the status address on success) into synthesizable state: PASS/FAIL/TIMEOUT flags, a cycle counter and a scratch register. It sits beside data memory in `top`, with address decode in parallel, so that FPGA builds report test outcome without a simulator.

---
 rtl/mmio_status_pkg.sv | 34 +++
 rtl/mmio_status_port_if.sv | 23 ++
 rtl/mmio_watchdog.sv | 31 +++
 rtl/mmio_status_port.sv | 162 ++++++++++++++++
 tb/tb_mmio_status_port.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_status_pkg.sv
// Shared types and constants for the MMIO status port.
// Holds the outcome FSM encoding, the register offsets inside the
// 32-byte window and the encoding of the CPU memwrite strobe.
package mmio_status_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  // Register index taken from offset bits [4:3]
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_SCRATCH = 2'd1;
  localparam logic [1:0] REG_CYCLE   = 2'd2;
  localparam logic [1:0] REG_STATE   = 2'd3;

  // memwrite encoding; 2'b11 behaves like MW_DWORD
  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_WORD  = 2'b01;
  localparam logic [1:0] MW_DWORD = 2'b10;

  localparam int WINDOW_BYTES = 32;

  // Places a 32-bit word into the low or high half of a doubleword,
  // keeping the other half from 'old'.
  function automatic logic [63:0] merge_word(input logic [63:0] old,
                                             input logic [31:0] word,
                                             input logic        upper);
    merge_word = upper ? {word, old[31:0]} : {old[63:32], word};
  endfunction

endpackage

// File: rtl/mmio_status_port_if.sv
// Data-memory bus as seen by the status port. The CPU side is the
// master; the status port (and data memory beside it) is the slave.
interface mmio_status_port_if;

  logic [1:0]  memwrite;
  logic        memread;
  logic [63:0] dataadr;
  logic [63:0] writedata;
  logic [63:0] readdata;
  logic        rvalid;
  logic        hit;

  modport master (
    output memwrite, memread, dataadr, writedata,
    input  readdata, rvalid, hit
  );

  modport slave (
    input  memwrite, memread, dataadr, writedata,
    output readdata, rvalid, hit
  );

endinterface

// File: rtl/mmio_watchdog.sv
// Saturating run-cycle counter with a terminal-count flag.
// o_tc is asserted combinationally while the count sits at TERMINAL-1
// and i_tc_en is high; it does not depend on i_en so the owner can use
// it to decide whether to keep counting without a loop.
module mmio_watchdog #(
  parameter int CNT_W    = 10,
  parameter int TERMINAL = 192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_tc_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = i_tc_en && (r_count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/mmio_status_port.sv
// MMIO status port: a 32-byte register window on the data-memory bus
// that records the self-check outcome of a test program.
//   +0x00 STATUS  (W)   7 -> PASS, other nonzero -> FAIL, 0 ignored
//   +0x08 SCRATCH (R/W)
//   +0x10 CYCLE   (R)   run-cycle count
//   +0x18 STATE   (R)   FSM state
// Define MMIO_STATUS_WATCHDOG_EN to let the port give up with TIMEOUT
// after TIMEOUT_CYCLES run cycles; otherwise timeout is tied low.
module mmio_status_port
  import mmio_status_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR      = 64'h80,
  parameter logic [63:0] PASS_VALUE     = 64'd7,
  parameter int          TIMEOUT_CYCLES = 192,
  parameter int          CNT_W          = 10
) (
  input  logic               clk,
  input  logic               reset,
  mmio_status_port_if.slave  bus,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycles
);

`ifdef MMIO_STATUS_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [63:0]      r_scratch;
  logic [63:0]      r_readdata;
  logic             r_rvalid;

  logic [63:0]      w_off;
  logic             w_hit;
  logic [1:0]       w_reg;
  logic             w_upper;
  logic             w_is_word;
  logic             w_is_dword;
  logic             w_wr;
  logic             w_status_wr;
  logic [63:0]      w_status_val;
  logic [63:0]      w_scratch_val;
  logic [63:0]      w_rdata;
  logic             w_tc;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_count;

  // Address decode: unsigned offset so addresses below the base wrap
  // to huge values and miss the window.
  assign w_off   = bus.dataadr - BASE_ADDR;
  assign w_hit   = (w_off < 64'(WINDOW_BYTES));
  assign w_reg   = w_off[4:3];
  assign w_upper = w_off[2];

  assign w_is_word  = (bus.memwrite == MW_WORD);
  assign w_is_dword = ((bus.memwrite & MW_DWORD) != MW_NONE);
  assign w_wr       = w_hit && (w_is_word || w_is_dword);

  // A word store to STATUS is judged as the full doubleword it would
  // produce with zeros in the untouched half.
  assign w_status_wr   = w_wr && (w_reg == REG_STATUS);
  assign w_status_val  = w_is_dword ? bus.writedata
                                    : merge_word(64'd0, bus.writedata[31:0], w_upper);
  assign w_scratch_val = w_is_dword ? bus.writedata
                                    : merge_word(r_scratch, bus.writedata[31:0], w_upper);

  // Count only on edges that stay in RUN so the value freezes at the
  // count seen when the outcome was decided.
  assign w_cnt_en = (r_state == RUN) && (w_state_next == RUN);

  mmio_watchdog #(
    .CNT_W   (CNT_W),
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_cnt_en),
    .i_tc_en(WD_EN),
    .o_count(w_count),
    .o_tc   (w_tc)
  );

  // Outcome state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decision: a STATUS write beats the terminal count
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_status_wr && (w_status_val == PASS_VALUE)) begin
          w_state_next = PASS;
        end else if (w_status_wr && (w_status_val != 64'd0)) begin
          w_state_next = FAIL;
        end else if (w_tc) begin
          w_state_next = TIMEOUT;
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  // Scratch register, writable in every state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scratch <= '0;
    end else if (w_wr && (w_reg == REG_SCRATCH)) begin
      r_scratch <= w_scratch_val;
    end
  end

  // Read mux over pre-edge register values
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_STATUS:  w_rdata = '0;
      REG_SCRATCH: w_rdata = r_scratch;
      REG_CYCLE:   w_rdata = {{(64-CNT_W){1'b0}}, w_count};
      REG_STATE:   w_rdata = {62'd0, r_state};
      default:     w_rdata = '0;
    endcase
  end

  // Registered read response; data holds between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rvalid <= bus.memread && w_hit;
      if (bus.memread && w_hit) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.rvalid   = r_rvalid;
  assign bus.hit      = w_hit;

  assign pass   = (r_state == PASS);
  assign fail   = (r_state == FAIL);
  assign cycles = w_count;

`ifdef MMIO_STATUS_WATCHDOG_EN
  assign timeout = (r_state == TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_status_port.sv
// Directed testbench for mmio_status_port. Each test task drives its
// own scenario and checks outputs against hand-computed values.
// Follows the MMIO_STATUS_WATCHDOG_EN setting of the build.
module tb_mmio_status_port;
  import mmio_status_pkg::*;

  logic       clk;
  logic       resetN;
  logic       passFlag;
  logic       failFlag;
  logic       timeoutFlag;
  logic [9:0] cycleCount;
  int         vecCount;
  int         errCount;

  mmio_status_port_if busIf();

  mmio_status_port dut (
    .clk    (clk),
    .reset  (resetN),
    .bus    (busIf),
    .pass   (passFlag),
    .fail   (failFlag),
    .timeout(timeoutFlag),
    .cycles (cycleCount)
  );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one bus transaction at the falling edge, let the DUT take it
   // on the rising edge, then return 1 time unit later with the bus idle.
   task automatic applyStimulus(input logic [1:0] mw, input logic rd,
                                input logic [63:0] addr, input logic [63:0] data);
      @(negedge clk);
      busIf.memwrite  = mw;
      busIf.memread   = rd;
      busIf.dataadr   = addr;
      busIf.writedata = data;
      @(posedge clk);
      #1;
      busIf.memwrite = MW_NONE;
      busIf.memread  = 1'b0;
   endtask

   // Assert reset for a while, then release it on a falling edge
   task automatic resetDut();
      busIf.memwrite  = MW_NONE;
      busIf.memread   = 1'b0;
      busIf.dataadr   = 64'd0;
      busIf.writedata = 64'd0;
      resetN = 1'b0;
      #7;
      @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      busIf.memwrite  = MW_NONE;
      busIf.memread   = 1'b0;
      busIf.dataadr   = 64'd0;
      busIf.writedata = 64'd0;
      #2 resetN = 1'b0;
      #1;
      vecCount++; if (busIf.readdata !== 64'd0) begin errCount++; $display("[TB] FAIL reset_readdata: got %h expected 0", busIf.readdata); end
      vecCount++; if (busIf.rvalid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_rvalid: got %b expected 0", busIf.rvalid); end
      vecCount++; if ({passFlag, failFlag, timeoutFlag} !== 3'b000) begin errCount++; $display("[TB] FAIL reset_flags: got %b expected 000", {passFlag, failFlag, timeoutFlag}); end
      vecCount++; if (cycleCount !== 10'd0) begin errCount++; $display("[TB] FAIL reset_cycles: got %0d expected 0", cycleCount); end
      @(negedge clk);
      resetN = 1'b1;
      applyStimulus(MW_NONE, 1'b1, 64'h88, 64'd0);
      vecCount++; if (busIf.readdata !== 64'd0 || busIf.rvalid !== 1'b1) begin errCount++; $display("[TB] FAIL reset_scratch: got %h/%b expected 0/1", busIf.readdata, busIf.rvalid); end
   endtask

   task automatic test_pass();
      resetDut();
      repeat (10) @(posedge clk);
      #1;
      vecCount++; if (cycleCount !== 10'd10) begin errCount++; $display("[TB] FAIL pass_precount: got %0d expected 10", cycleCount); end
      applyStimulus(MW_DWORD, 1'b0, 64'h80, 64'd7);
      vecCount++; if ({passFlag, failFlag, timeoutFlag} !== 3'b100) begin errCount++; $display("[TB] FAIL pass_flags: got %b expected 100", {passFlag, failFlag, timeoutFlag}); end
      vecCount++; if (cycleCount !== 10'd10) begin errCount++; $display("[TB] FAIL pass_cycles: got %0d expected 10", cycleCount); end
      repeat (3) @(posedge clk);
      #1;
      vecCount++; if (cycleCount !== 10'd10) begin errCount++; $display("[TB] FAIL pass_frozen: got %0d expected 10", cycleCount); end
      applyStimulus(MW_NONE, 1'b1, 64'h98, 64'd0);
      vecCount++; if (busIf.rvalid !== 1'b1 || busIf.readdata !== 64'd1) begin errCount++; $display("[TB] FAIL pass_state_read: got %h/%b expected 1/1", busIf.readdata, busIf.rvalid); end
      applyStimulus(MW_NONE, 1'b1, 64'h90, 64'd0);
      vecCount++; if (busIf.readdata !== 64'd10) begin errCount++; $display("[TB] FAIL pass_cycle_read: got %h expected a", busIf.readdata); end
      applyStimulus(MW_NONE, 1'b0, 64'h90, 64'd0);
      vecCount++; if (busIf.rvalid !== 1'b0 || busIf.readdata !== 64'd10) begin errCount++; $display("[TB] FAIL pass_rvalid_pulse: got %h/%b expected a/0", busIf.readdata, busIf.rvalid); end
   endtask

   task automatic test_fail();
      resetDut();
      applyStimulus(MW_WORD, 1'b0, 64'h84, 64'd7);
      vecCount++; if ({passFlag, failFlag, timeoutFlag} !== 3'b010) begin errCount++; $display("[TB] FAIL fail_flags: got %b expected 010", {passFlag, failFlag, timeoutFlag}); end
      applyStimulus(MW_DWORD, 1'b0, 64'h80, 64'd7);
      vecCount++; if ({passFlag, failFlag, timeoutFlag} !== 3'b010) begin errCount++; $display("[TB] FAIL fail_sticky: got %b expected 010", {passFlag, failFlag, timeoutFlag}); end
      applyStimulus(MW_NONE, 1'b1, 64'h98, 64'd0);
      vecCount++; if (busIf.readdata !== 64'd2) begin errCount++; $display("[TB] FAIL fail_state_read: got %h expected 2", busIf.readdata); end
   endtask

   task automatic test_timeout();
      resetDut();
`ifdef MMIO_STATUS_WATCHDOG_EN
      repeat (191) @(posedge clk);
      #1;
      vecCount++; if (timeoutFlag !== 1'b0 || cycleCount !== 10'd191) begin errCount++; $display("[TB] FAIL timeout_before: got %b/%0d expected 0/191", timeoutFlag, cycleCount); end
      @(posedge clk);
      #1;
      vecCount++; if (timeoutFlag !== 1'b1 || cycleCount !== 10'd191) begin errCount++; $display("[TB] FAIL timeout_enter: got %b/%0d expected 1/191", timeoutFlag, cycleCount); end
      repeat (5) @(posedge clk);
      applyStimulus(MW_NONE, 1'b1, 64'h98, 64'd0);
      vecCount++; if (busIf.readdata !== 64'd3 || cycleCount !== 10'd191) begin errCount++; $display("[TB] FAIL timeout_state: got %h/%0d expected 3/191", busIf.readdata, cycleCount); end
`else
      repeat (192) @(posedge clk);
      #1;
      vecCount++; if (timeoutFlag !== 1'b0 || cycleCount !== 10'd192) begin errCount++; $display("[TB] FAIL nowd_count: got %b/%0d expected 0/192", timeoutFlag, cycleCount); end
      repeat (831) @(posedge clk);
      #1;
      vecCount++; if (cycleCount !== 10'd1023) begin errCount++; $display("[TB] FAIL nowd_saturate: got %0d expected 1023", cycleCount); end
      repeat (4) @(posedge clk);
      applyStimulus(MW_NONE, 1'b1, 64'h98, 64'd0);
      vecCount++; if (cycleCount !== 10'd1023 || busIf.readdata !== 64'd0 || timeoutFlag !== 1'b0) begin errCount++; $display("[TB] FAIL nowd_hold: got %0d/%h/%b expected 1023/0/0", cycleCount, busIf.readdata, timeoutFlag); end
`endif
   endtask

   task automatic test_status_race();
      resetDut();
      repeat (191) @(posedge clk);
      #1;
      applyStimulus(MW_DWORD, 1'b0, 64'h80, 64'd7);
      vecCount++; if ({passFlag, failFlag, timeoutFlag} !== 3'b100) begin errCount++; $display("[TB] FAIL race_flags: got %b expected 100", {passFlag, failFlag, timeoutFlag}); end
      vecCount++; if (cycleCount !== 10'd191) begin errCount++; $display("[TB] FAIL race_cycles: got %0d expected 191", cycleCount); end
   endtask

   task automatic test_scratch();
      resetDut();
      applyStimulus(MW_DWORD, 1'b0, 64'h88, 64'hDEADBEEF_CAFEF00D);
      applyStimulus(MW_WORD, 1'b0, 64'h88, 64'h00000000_12345678);
      applyStimulus(MW_NONE, 1'b1, 64'h88, 64'd0);
      vecCount++; if (busIf.rvalid !== 1'b1 || busIf.readdata !== 64'hDEADBEEF_12345678) begin errCount++; $display("[TB] FAIL scratch_low: got %h/%b expected deadbeef12345678/1", busIf.readdata, busIf.rvalid); end
      applyStimulus(2'b11, 1'b0, 64'h8C, 64'hFFFFFFFF_A5A5A5A5);
      applyStimulus(MW_WORD, 1'b0, 64'h8C, 64'hFFFFFFFF_A5A5A5A5);
      applyStimulus(MW_NONE, 1'b1, 64'h8C, 64'd0);
      vecCount++; if (busIf.readdata !== 64'hA5A5A5A5_A5A5A5A5) begin errCount++; $display("[TB] FAIL scratch_high: got %h expected a5a5a5a5a5a5a5a5", busIf.readdata); end
      applyStimulus(MW_DWORD, 1'b1, 64'h88, 64'h00000000_00001111);
      vecCount++; if (busIf.readdata !== 64'hA5A5A5A5_A5A5A5A5) begin errCount++; $display("[TB] FAIL scratch_rw_same: got %h expected a5a5a5a5a5a5a5a5", busIf.readdata); end
      applyStimulus(MW_NONE, 1'b1, 64'h88, 64'd0);
      vecCount++; if (busIf.readdata !== 64'h00000000_00001111) begin errCount++; $display("[TB] FAIL scratch_after: got %h expected 1111", busIf.readdata); end
      vecCount++; if ({passFlag, failFlag} !== 2'b00) begin errCount++; $display("[TB] FAIL scratch_no_flag: got %b expected 00", {passFlag, failFlag}); end
   endtask

   task automatic test_outside();
      logic [63:0] addrs [4];
      logic        hits  [4];
      resetDut();
      @(negedge clk);
      busIf.memwrite  = MW_DWORD;
      busIf.dataadr   = 64'h54;
      busIf.writedata = 64'd7;
      #1;
      vecCount++; if (busIf.hit !== 1'b0) begin errCount++; $display("[TB] FAIL outside_hit: got %b expected 0", busIf.hit); end
      @(posedge clk);
      #1;
      busIf.memwrite = MW_NONE;
      @(posedge clk);
      #1;
      vecCount++; if ({passFlag, failFlag, timeoutFlag} !== 3'b000) begin errCount++; $display("[TB] FAIL outside_flags: got %b expected 000", {passFlag, failFlag, timeoutFlag}); end
      applyStimulus(MW_NONE, 1'b1, 64'h54, 64'd0);
      vecCount++; if (busIf.rvalid !== 1'b0) begin errCount++; $display("[TB] FAIL outside_rvalid: got %b expected 0", busIf.rvalid); end
      addrs = '{64'h7F, 64'h80, 64'h9F, 64'hA0};
      hits  = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         busIf.dataadr = addrs[i];
         #1;
         vecCount++; if (busIf.hit !== hits[i]) begin errCount++; $display("[TB] FAIL hit_edge_%0h: got %b expected %b", addrs[i], busIf.hit, hits[i]); end
      end
   endtask

   task automatic test_async_reset();
      resetDut();
      repeat (4) @(posedge clk);
      applyStimulus(MW_DWORD, 1'b0, 64'h88, 64'h55);
      applyStimulus(MW_DWORD, 1'b0, 64'h80, 64'd7);
      applyStimulus(MW_NONE, 1'b1, 64'h98, 64'd0);
      #1;
      resetN = 1'b0;
      #1;
      vecCount++; if ({passFlag, failFlag, timeoutFlag, busIf.rvalid} !== 4'b0000) begin errCount++; $display("[TB] FAIL async_flags: got %b expected 0000", {passFlag, failFlag, timeoutFlag, busIf.rvalid}); end
      vecCount++; if (cycleCount !== 10'd0 || busIf.readdata !== 64'd0) begin errCount++; $display("[TB] FAIL async_data: got %0d/%h expected 0/0", cycleCount, busIf.readdata); end
      @(negedge clk);
      resetN = 1'b1;
      applyStimulus(MW_NONE, 1'b1, 64'h88, 64'd0);
      vecCount++; if (busIf.readdata !== 64'd0) begin errCount++; $display("[TB] FAIL async_scratch: got %h expected 0", busIf.readdata); end
   endtask

   // Run every scenario in order, then report
   initial begin
      vecCount = 0;
      errCount = 0;
      resetN   = 1'b1;
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_status_race();
      test_scratch();
      test_outside();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
